// File: rtl/pri_decoder_if.sv
// Handshake bundle between the encoder-side producer, the decoder and the grant consumers.
interface pri_decoder_if #(
  parameter int unsigned IDX_W = 2,
  parameter int unsigned OUT_W = 4
);
  logic [IDX_W:0]   code_in;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] data_out;
  logic             err_out;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  code_in, in_valid, out_ready,
    output in_ready, data_out, err_out, out_valid
  );

  modport master (
    output code_in, in_valid, out_ready,
    input  in_ready, data_out, err_out, out_valid
  );
endinterface

// File: rtl/pri_decoder.sv
// Priority decoder: turns {valid, index} codes back into one-hot grants through a
// 2-entry buffer, flagging out-of-range indices and counting accepted codes.
module pri_decoder #(
  parameter int unsigned IDX_W = 2,
  parameter int unsigned OUT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pri_decoder_if.slave     bus,
  input  logic             clr,
  output logic             err_sticky,
  output logic [CNT_W-1:0] acc_cnt
);

  localparam logic [IDX_W:0] OUT_W_L = (IDX_W+1)'(OUT_W);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_head_data;
  logic             r_head_err;
  logic [OUT_W-1:0] r_tail_data;
  logic             r_tail_err;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_acc_cnt;

  logic             w_push;
  logic             w_pop;
  logic             w_load_head;
  logic             w_load_tail;
  logic             w_head_from_tail;
  logic             w_clear_head;
  logic [IDX_W-1:0] w_idx;
  logic [OUT_W-1:0] w_dec_data;
  logic             w_dec_err;

  assign w_push = bus.in_valid && r_in_ready;
  assign w_pop  = r_out_valid && bus.out_ready;
  assign w_idx  = bus.code_in[IDX_W-1:0];

  // Decode at accept time; an invalid code is a legal empty request.
  always_comb begin
    w_dec_data = '0;
    w_dec_err  = 1'b0;
    if (bus.code_in[IDX_W]) begin
      if ({1'b0, w_idx} >= OUT_W_L) w_dec_err = 1'b1;
      else                          w_dec_data = OUT_W'(1) << w_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Occupancy FSM; a full buffer never sees a push because in_ready is low.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_head      = 1'b0;
    w_load_tail      = 1'b0;
    w_head_from_tail = 1'b0;
    w_clear_head     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_state_nxt = S_ONE;
          w_load_head = 1'b1;
        end
      end
      S_ONE: begin
        if (w_push && w_pop) begin
          w_load_head = 1'b1;
        end else if (w_push) begin
          w_state_nxt = S_FULL;
          w_load_tail = 1'b1;
        end else if (w_pop) begin
          w_state_nxt  = S_EMPTY;
          w_clear_head = 1'b1;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_state_nxt      = S_ONE;
          w_head_from_tail = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head_data <= '0;
      r_head_err  <= 1'b0;
      r_tail_data <= '0;
      r_tail_err  <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
      if (w_load_head) begin
        r_head_data <= w_dec_data;
        r_head_err  <= w_dec_err;
      end else if (w_head_from_tail) begin
        r_head_data <= r_tail_data;
        r_head_err  <= r_tail_err;
      end else if (w_clear_head) begin
        r_head_data <= '0;
        r_head_err  <= 1'b0;
      end
      if (w_load_tail) begin
        r_tail_data <= w_dec_data;
        r_tail_err  <= w_dec_err;
      end
    end
  end

  // clr wins over history but not over a coincident accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else if (clr) begin
      r_acc_cnt    <= w_push ? CNT_W'(1) : '0;
      r_err_sticky <= w_push && w_dec_err;
    end else if (w_push) begin
      r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      if (w_dec_err) r_err_sticky <= 1'b1;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.data_out  = r_head_data;
  assign bus.err_out   = r_head_err;
  assign err_sticky    = r_err_sticky;
  assign acc_cnt       = r_acc_cnt;

endmodule

// File: tb/tb_pri_decoder.sv
// Directed and scoreboarded checks of pri_decoder with OUT_W=4 and OUT_W=3 instances.
module tb_pri_decoder;

  logic       clk;
  logic       rst_n;
  logic       clr4;
  logic       clr3;
  logic       sticky4;
  logic       sticky3;
  logic [7:0] acc4;
  logic [7:0] acc3;

  int n_cmp;
  int n_bad;

  pri_decoder_if #(.IDX_W(2), .OUT_W(4)) bus4 ();
  pri_decoder_if #(.IDX_W(2), .OUT_W(3)) bus3 ();

  pri_decoder #(.IDX_W(2), .OUT_W(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .clr(clr4),
    .err_sticky(sticky4), .acc_cnt(acc4)
  );

  pri_decoder #(.IDX_W(2), .OUT_W(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .clr(clr3),
    .err_sticky(sticky3), .acc_cnt(acc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] ref_dec4(input logic [2:0] code);
    logic [3:0] r;
    r = 4'b0000;
    if (code[2]) r[code[1:0]] = 1'b1;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] sweep_code [5];
    logic [3:0] sweep_exp  [5];
    logic [3:0] q [$];
    logic [2:0] cur;
    logic       have;
    logic       acc_now;
    logic       pop_now;
    int         sent;

    n_cmp = 0;
    n_bad = 0;
    sweep_code = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b000};
    sweep_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

    rst_n = 1'b1;
    clr4 = 1'b0; clr3 = 1'b0;
    bus4.code_in = '0; bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    bus3.code_in = '0; bus3.in_valid = 1'b0; bus3.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ovld", 32'(bus4.out_valid), 32'd0);
    chk("rst_irdy", 32'(bus4.in_ready), 32'd1);
    chk("rst_data", 32'(bus4.data_out), 32'd0);
    chk("rst_err", 32'(bus4.err_out), 32'd0);
    chk("rst_sticky", 32'(sticky4), 32'd0);
    chk("rst_acc", 32'(acc4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single code, one-cycle latency
    bus4.code_in = 3'b110; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    chk("t1_ovld", 32'(bus4.out_valid), 32'd1);
    chk("t1_data", 32'(bus4.data_out), 32'h4);
    chk("t1_err", 32'(bus4.err_out), 32'd0);
    chk("t1_acc", 32'(acc4), 32'd1);
    step();
    chk("t1_drain", 32'(bus4.out_valid), 32'd0);

    clr4 = 1'b1;
    step();
    clr4 = 1'b0;
    chk("clr_acc", 32'(acc4), 32'd0);

    // Sweep with out_ready high: simultaneous push/pop keeps the newest code at head
    for (int i = 0; i < 5; i++) begin
      bus4.code_in = sweep_code[i]; bus4.in_valid = 1'b1;
      step();
      chk($sformatf("sweep_data%0d", i), 32'(bus4.data_out), 32'(sweep_exp[i]));
      chk($sformatf("sweep_irdy%0d", i), 32'(bus4.in_ready), 32'd1);
    end
    bus4.in_valid = 1'b0;
    step();
    chk("sweep_acc", 32'(acc4), 32'd5);
    chk("sweep_sticky", 32'(sticky4), 32'd0);
    chk("sweep_empty", 32'(bus4.out_valid), 32'd0);

    // Backpressure
    bus4.out_ready = 1'b0;
    bus4.code_in = 3'b101; bus4.in_valid = 1'b1;
    step();
    chk("bp_irdy1", 32'(bus4.in_ready), 32'd1);
    chk("bp_data1", 32'(bus4.data_out), 32'h2);
    bus4.code_in = 3'b111;
    step();
    chk("bp_irdy2", 32'(bus4.in_ready), 32'd0);
    chk("bp_data2", 32'(bus4.data_out), 32'h2);
    bus4.code_in = 3'b100;
    step();
    chk("bp_irdy3", 32'(bus4.in_ready), 32'd0);
    chk("bp_hold", 32'(bus4.data_out), 32'h2);
    chk("bp_acc3", 32'(acc4), 32'd7);
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    chk("bp_pop_data", 32'(bus4.data_out), 32'h8);
    chk("bp_pop_irdy", 32'(bus4.in_ready), 32'd1);
    chk("bp_pop_ovld", 32'(bus4.out_valid), 32'd1);
    step();
    bus4.in_valid = 1'b0;
    chk("bp_late_acc", 32'(acc4), 32'd8);
    chk("bp_late_data", 32'(bus4.data_out), 32'h8);
    bus4.out_ready = 1'b1;
    step();
    chk("bp_tail_data", 32'(bus4.data_out), 32'h1);
    step();
    chk("bp_drained", 32'(bus4.out_valid), 32'd0);

    // Scoreboard: 40 random codes, random out_ready
    sent = 0; have = 1'b0; cur = '0;
    for (int cyc = 0; cyc < 2000 && (sent < 40 || q.size() > 0); cyc++) begin
      if (!have && sent < 40) begin
        cur  = 3'($urandom_range(0, 7));
        have = 1'b1;
      end
      bus4.code_in   = cur;
      bus4.in_valid  = have;
      bus4.out_ready = 1'($urandom_range(0, 1));
      chk("sb_ovld", 32'(bus4.out_valid), 32'(q.size() > 0));
      chk("sb_irdy", 32'(bus4.in_ready), 32'(q.size() < 2));
      pop_now = bus4.out_valid && bus4.out_ready;
      acc_now = have && bus4.in_ready;
      if (pop_now && q.size() > 0) begin
        chk("sb_data", 32'(bus4.data_out), 32'(q[0]));
        chk("sb_err", 32'(bus4.err_out), 32'd0);
        void'(q.pop_front());
      end
      if (acc_now) begin
        q.push_back(ref_dec4(cur));
        sent++;
        have = 1'b0;
      end
      step();
    end
    bus4.in_valid = 1'b0;
    chk("sb_done", 32'(sent == 40 && q.size() == 0), 32'd1);
    chk("sb_acc", 32'(acc4), 32'd48);

    // Error path on the OUT_W=3 instance; index 3 is out of range
    bus3.code_in = 3'b111; bus3.in_valid = 1'b1; bus3.out_ready = 1'b1;
    step();
    chk("e_data", 32'(bus3.data_out), 32'd0);
    chk("e_err", 32'(bus3.err_out), 32'd1);
    chk("e_sticky", 32'(sticky3), 32'd1);
    bus3.code_in = 3'b110;
    step();
    bus3.in_valid = 1'b0;
    chk("e_in_range_data", 32'(bus3.data_out), 32'h4);
    chk("e_in_range_err", 32'(bus3.err_out), 32'd0);
    chk("e_sticky_kept", 32'(sticky3), 32'd1);
    chk("e_acc", 32'(acc3), 32'd2);
    clr3 = 1'b1;
    step();
    chk("e_clr_sticky", 32'(sticky3), 32'd0);
    chk("e_clr_acc", 32'(acc3), 32'd0);
    bus3.code_in = 3'b111; bus3.in_valid = 1'b1;
    step();
    chk("e_clracc_sticky", 32'(sticky3), 32'd1);
    chk("e_clracc_acc", 32'(acc3), 32'd1);
    bus3.code_in = 3'b101;
    step();
    clr3 = 1'b0;
    bus3.in_valid = 1'b0;
    chk("e_clrok_sticky", 32'(sticky3), 32'd0);
    chk("e_clrok_acc", 32'(acc3), 32'd1);
    chk("e_clrok_data", 32'(bus3.data_out), 32'h2);

    // Async reset with two entries buffered
    bus4.out_ready = 1'b0;
    bus4.code_in = 3'b101; bus4.in_valid = 1'b1;
    step();
    bus4.code_in = 3'b111;
    step();
    bus4.in_valid = 1'b0;
    chk("ar_full", 32'(bus4.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ovld", 32'(bus4.out_valid), 32'd0);
    chk("ar_data", 32'(bus4.data_out), 32'd0);
    chk("ar_irdy", 32'(bus4.in_ready), 32'd1);
    chk("ar_acc", 32'(acc4), 32'd0);
    chk("ar_sticky3", 32'(sticky3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus4.code_in = 3'b110; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    chk("ar_first_ovld", 32'(bus4.out_valid), 32'd1);
    chk("ar_first_data", 32'(bus4.data_out), 32'h4);
    chk("ar_first_acc", 32'(acc4), 32'd1);

    // Counter wrap after 256 accepts
    clr4 = 1'b1;
    step();
    clr4 = 1'b0;
    bus4.code_in = 3'b100; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    for (int i = 0; i < 255; i++) step();
    chk("wrap_255", 32'(acc4), 32'd255);
    step();
    bus4.in_valid = 1'b0;
    chk("wrap_0", 32'(acc4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
